// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - state encoding and default timing for the RTC bus sequencer
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A_SU,
    A_PW,
    A_HD,
    D_SU,
    D_PW,
    D_HD,
    REC
  } state_t;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_T_SU  = 4;
  localparam int DEF_T_PW  = 8;
  localparam int DEF_T_HD  = 4;
  localparam int DEF_T_REC = 4;

  // A programmed width of zero still has to occupy one cycle.
  function automatic int eff_time(input int t);
    return (t == 0) ? 1 : t;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable saturating down-counter with a zero flag
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   load_i       load load_val_i this cycle (takes priority over counting)
//   load_val_i   value loaded on phase entry (phase length - 1)
//   zero_o       count has reached 0, i.e. this is the last cycle of the phase
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturates at 0 so a stalled phase can never wrap into a long count.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - multiplexed address/data RTC bus transaction sequencer
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   req, rw, addr, wdata transaction request (sampled in IDLE only) and its operands
//   busy, done, rdata    status towards the requester; rdata holds the last read
//   cs_n, ad_n, wr_n, rd_n  registered RTC bus strobes
//   bus_dout, bus_oe_n, bus_din  interface to the tristate pad wrapper
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int T_SU  = DEF_T_SU,
  parameter int T_PW  = DEF_T_PW,
  parameter int T_HD  = DEF_T_HD,
  parameter int T_REC = DEF_T_REC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] bus_dout,
  output logic       bus_oe_n,
  input  logic [7:0] bus_din
);

  localparam logic [CNT_W-1:0] SU_LD  = CNT_W'(eff_time(T_SU) - 1);
  localparam logic [CNT_W-1:0] PW_LD  = CNT_W'(eff_time(T_PW) - 1);
  localparam logic [CNT_W-1:0] HD_LD  = CNT_W'(eff_time(T_HD) - 1);
  localparam logic [CNT_W-1:0] REC_LD = CNT_W'(eff_time(T_REC) - 1);

  state_t state_q, state_d;
  logic             rw_q, rw_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cs_n_q, cs_n_d, ad_n_q, ad_n_d;
  logic             wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic             oe_n_q, oe_n_d;
  logic [7:0]       dout_q, dout_d;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             accept;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign accept  = (state_q == IDLE) && req;
  assign rw_d    = accept ? rw    : rw_q;
  assign addr_d  = accept ? addr  : addr_q;
  assign wdata_d = accept ? wdata : wdata_q;

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: if (req)      begin state_d = A_SU; tmr_load = 1'b1; tmr_val = SU_LD;  end
      A_SU: if (tmr_zero) begin state_d = A_PW; tmr_load = 1'b1; tmr_val = PW_LD;  end
      A_PW: if (tmr_zero) begin state_d = A_HD; tmr_load = 1'b1; tmr_val = HD_LD;  end
      A_HD: if (tmr_zero) begin state_d = D_SU; tmr_load = 1'b1; tmr_val = SU_LD;  end
      D_SU: if (tmr_zero) begin state_d = D_PW; tmr_load = 1'b1; tmr_val = PW_LD;  end
      D_PW: if (tmr_zero) begin state_d = D_HD; tmr_load = 1'b1; tmr_val = HD_LD;  end
      D_HD: if (tmr_zero) begin state_d = REC;  tmr_load = 1'b1; tmr_val = REC_LD; end
      REC:  if (tmr_zero) begin state_d = IDLE; end
      default:            begin state_d = IDLE; end
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so they
  // change on the same edge as the state and never glitch.
  always_comb begin
    cs_n_d = 1'b1;
    ad_n_d = 1'b1;
    wr_n_d = 1'b1;
    rd_n_d = 1'b1;
    oe_n_d = 1'b1;
    dout_d = dout_q;
    busy_d = (state_d != IDLE);
    done_d = (state_q == D_HD) && (state_d == REC);
    unique case (state_d)
      A_SU, A_PW, A_HD: begin
        cs_n_d = 1'b0;
        ad_n_d = 1'b0;
        oe_n_d = 1'b0;
        dout_d = addr_d;
        wr_n_d = (state_d != A_PW);
      end
      D_SU, D_PW, D_HD: begin
        cs_n_d = 1'b0;
        if (!rw_d) begin
          oe_n_d = 1'b0;
          dout_d = wdata_d;
          wr_n_d = (state_d != D_PW);
        end else begin
          // Read: pad stays released so the RTC can drive the bus.
          rd_n_d = (state_d != D_PW);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ad_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
      ad_n_q  <= ad_n_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      oe_n_q  <= oe_n_d;
      dout_q  <= dout_d;
      // Capture on the edge that ends the last read-strobe cycle.
      if ((state_q == D_PW) && tmr_zero && rw_q) begin
        rdata_q <= bus_din;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign cs_n     = cs_n_q;
  assign ad_n     = ad_n_q;
  assign wr_n     = wr_n_q;
  assign rd_n     = rd_n_q;
  assign bus_dout = dout_q;
  assign bus_oe_n = oe_n_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - self-checking bench for rtc_bus_sequencer
module tb_rtc_bus_sequencer;

  typedef struct packed {
    logic       busy, done, cs_n, ad_n, wr_n, rd_n, oe_n;
    logic [7:0] dout;
  } bus_t;

  logic       clk = 1'b0;
  logic       reset, req, rw, sel;
  logic [7:0] addr, wdata, bus_din;
  logic       req1, req2;

  logic       busy1, done1, cs1, ad1, wr1, rd1, oe1;
  logic [7:0] rdata1, dout1;
  logic       busy2, done2, cs2, ad2, wr2, rd2, oe2;
  logic [7:0] rdata2, dout2;

  logic       o_busy, o_done, o_cs, o_ad, o_wr, o_rd, o_oe;
  logic [7:0] o_rdata, o_dout;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rdata [2];
  int n_busy, n_done_k, n_wra, n_wrd, n_rd;

  always #5 clk = ~clk;

  assign req1 = req & ~sel;
  assign req2 = req & sel;

  rtc_bus_sequencer u_dut (
    .clk(clk), .reset(reset), .req(req1), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1), .cs_n(cs1), .ad_n(ad1),
    .wr_n(wr1), .rd_n(rd1), .bus_dout(dout1), .bus_oe_n(oe1), .bus_din(bus_din)
  );

  rtc_bus_sequencer #(.T_SU(0), .T_PW(1), .T_HD(0), .T_REC(0)) u_fast (
    .clk(clk), .reset(reset), .req(req2), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy2), .done(done2), .rdata(rdata2), .cs_n(cs2), .ad_n(ad2),
    .wr_n(wr2), .rd_n(rd2), .bus_dout(dout2), .bus_oe_n(oe2), .bus_din(bus_din)
  );

  always_comb begin
    {o_busy, o_done, o_cs, o_ad, o_wr, o_rd, o_oe} = {busy1, done1, cs1, ad1, wr1, rd1, oe1};
    o_rdata = rdata1;
    o_dout  = dout1;
    if (sel) begin
      {o_busy, o_done, o_cs, o_ad, o_wr, o_rd, o_oe} = {busy2, done2, cs2, ad2, wr2, rd2, oe2};
      o_rdata = rdata2;
      o_dout  = dout2;
    end
  end

  // Expected bus picture for cycle k after the req-sampling edge, derived
  // from the cumulative phase lengths of one transaction.
  function automatic bus_t model(input int k, input int su, input int pw, input int hd,
                                 input int rec, input bit r, input logic [7:0] a_,
                                 input logic [7:0] w_);
    bus_t e;
    int p1 = su, p2 = su + pw, p3 = p2 + hd, p4 = p3 + su, p5 = p4 + pw;
    int p6 = p5 + hd, p7 = p6 + rec;
    e.busy = (k >= 1) && (k <= p7);
    e.done = (k == p6 + 1);
    e.cs_n = !((k >= 1) && (k <= p6));
    e.ad_n = !((k >= 1) && (k <= p3));
    e.wr_n = !(((k > p1) && (k <= p2)) || (!r && (k > p4) && (k <= p5)));
    e.rd_n = !(r && (k > p4) && (k <= p5));
    e.oe_n = !(((k >= 1) && (k <= p3)) || (!r && (k > p3) && (k <= p6)));
    e.dout = (k <= p3) ? a_ : w_;
    return e;
  endfunction

  task automatic run_txn(input string tag, input bit r, input logic [7:0] a_,
                         input logic [7:0] w_, input logic [7:0] din, input int inject_k);
    int su, pw, hd, rec, p3, p4, p5, p6, p7;
    bus_t e;
    logic [6:0] ev, ov;
    if (sel) begin su = 1; pw = 1; hd = 1; rec = 1; end
    else     begin su = 4; pw = 8; hd = 4; rec = 4; end
    p3 = 2 * su + pw - su + hd - (su + pw + hd) + (su + pw + hd); // address phase end
    p3 = su + pw + hd;
    p4 = p3 + su; p5 = p4 + pw; p6 = p5 + hd; p7 = p6 + rec;
    n_busy = 0; n_done_k = -1; n_wra = 0; n_wrd = 0; n_rd = 0;
    @(negedge clk);
    rw = r; addr = a_; wdata = w_; req = 1'b1; bus_din = 8'($urandom);
    @(negedge clk);
    req = 1'b0; rw = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
    for (int k = 1; k <= p7 + 1; k++) begin
      bus_din = ((k > p4) && (k <= p5)) ? din : 8'($urandom);
      if (inject_k == k) begin req = 1'b1; addr = 8'h55; rw = ~r; end
      else if (inject_k == k - 1) req = 1'b0;
      e  = model(k, su, pw, hd, rec, r, a_, w_);
      ev = {e.busy, e.done, e.cs_n, e.ad_n, e.wr_n, e.rd_n, e.oe_n};
      ov = {o_busy, o_done, o_cs, o_ad, o_wr, o_rd, o_oe};
      checks++;
      if (ov !== ev) begin
        errors++;
        $display("FAIL %s ctl cycle %0d: got %b required %b (busy,done,cs,ad,wr,rd,oe)", tag, k, ov, ev);
      end
      if (!e.oe_n) begin
        checks++;
        if (o_dout !== e.dout) begin
          errors++;
          $display("FAIL %s bus_dout cycle %0d: got %h required %h", tag, k, o_dout, e.dout);
        end
      end
      checks++;
      if ((!o_wr && !o_rd) || (!o_oe && !o_rd)) begin
        errors++;
        $display("FAIL %s strobe_invariant cycle %0d: got wr=%b rd=%b oe=%b required no overlap", tag, k, o_wr, o_rd, o_oe);
      end
      if (k == p6 + 1) begin
        if (r) exp_rdata[sel] = din;
        checks++;
        if (o_rdata !== exp_rdata[sel]) begin
          errors++;
          $display("FAIL %s rdata at done: got %h required %h", tag, o_rdata, exp_rdata[sel]);
        end
      end
      if (o_busy) n_busy++;
      if (o_done && n_done_k < 0) n_done_k = k;
      if (!o_wr && o_ad === 1'b0) n_wra++;
      if (!o_wr && o_ad === 1'b1) n_wrd++;
      if (!o_rd) n_rd++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    logic [6:0] v1, v2;
    v1 = {busy1, done1, cs1, ad1, wr1, rd1, oe1};
    v2 = {busy2, done2, cs2, ad2, wr2, rd2, oe2};
    checks++;
    if (v1 !== 7'b0011111 || v2 !== 7'b0011111) begin
      errors++;
      $display("FAIL %s ctl: got %b/%b required 0011111", tag, v1, v2);
    end
    checks++;
    if (dout1 !== 8'h00 || dout2 !== 8'h00 || rdata1 !== 8'h00 || rdata2 !== 8'h00) begin
      errors++;
      $display("FAIL %s data: got dout %h/%h rdata %h/%h required 00", tag, dout1, dout2, rdata1, rdata2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; bus_din = 8'h00; sel = 1'b0;
    exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
    #12;
    check_reset_values("reset");
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("post_reset_idle");
  endtask

  task automatic test_write_defaults();
    sel = 1'b0;
    run_txn("write_def", 1'b0, 8'h21, 8'hA5, 8'h00, 0);
    checks++;
    if (n_wra != 8 || n_wrd != 8) begin
      errors++; $display("FAIL write_def wr_low: got %0d/%0d required 8/8", n_wra, n_wrd);
    end
    checks++;
    if (n_done_k != 33 || n_busy != 36) begin
      errors++; $display("FAIL write_def timing: got done %0d busy %0d required 33/36", n_done_k, n_busy);
    end
  endtask

  task automatic test_read();
    sel = 1'b0;
    run_txn("read", 1'b1, 8'h0C, 8'h00, 8'h37, 0);
    checks++;
    if (n_rd != 8 || n_wrd != 0 || n_wra != 8) begin
      errors++; $display("FAIL read strobes: got rd %0d wr_data %0d wr_addr %0d required 8/0/8", n_rd, n_wrd, n_wra);
    end
    checks++;
    if (rdata1 !== 8'h37) begin
      errors++; $display("FAIL read rdata_hold: got %h required 37", rdata1);
    end
  endtask

  task automatic test_busy_reject();
    int extra;
    sel = 1'b0;
    run_txn("busy_reject", 1'b0, 8'h9E, 8'h3B, 8'h00, 6);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy1 || !cs1) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL busy_reject second_txn: got %0d active cycles required 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    sel = 1'b0;
    @(negedge clk); rw = 1'b0; addr = 8'h3C; wdata = 8'h5A; req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (22) @(negedge clk);
    checks++;
    if (wr1 !== 1'b0 || ad1 !== 1'b1) begin
      errors++; $display("FAIL reset_mid in_dpw: got wr=%b ad=%b required 0/1", wr1, ad1);
    end
    #2 reset = 1'b1;
    #1;
    exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
    check_reset_values("reset_mid_async");
    @(negedge clk); reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done1 || busy1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_mid no_done: got %0d active cycles required 0", seen);
    end
    run_txn("after_reset", 1'b0, 8'h44, 8'h99, 8'h00, 0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    @(negedge clk); rw = 1'b0; addr = 8'h12; wdata = 8'h34; req = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 74; k++) begin
      if (k == 40) req = 1'b0;
      checks++;
      if (busy1 !== ((k % 37) != 0) || done1 !== (k == 33 || k == 70)) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got busy=%b done=%b required %b/%b", k, busy1, done1,
                 ((k % 37) != 0), (k == 33 || k == 70));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fast_params();
    sel = 1'b1;
    run_txn("fast_write", 1'b0, 8'($urandom), 8'($urandom), 8'h00, 0);
    checks++;
    if (n_busy != 7 || n_done_k != 7) begin
      errors++; $display("FAIL fast_write timing: got busy %0d done %0d required 7/7", n_busy, n_done_k);
    end
    run_txn("fast_read", 1'b1, 8'($urandom), 8'h00, 8'($urandom), 0);
    checks++;
    if (n_rd != 1 || n_wra != 1) begin
      errors++; $display("FAIL fast_read strobes: got rd %0d wr_addr %0d required 1/1", n_rd, n_wra);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom);
      run_txn("random", 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
    end
  endtask

  initial begin
    test_reset();
    test_write_defaults();
    test_read();
    test_busy_reject();
    test_reset_mid();
    test_back_to_back();
    test_fast_params();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
